// File: rtl/jtpopeye_obj_pkg.sv
// Shared definitions for the Popeye object ROM bank block.
//   DefNb / DefAw : default bank count and bank address width.
//   obj_state_e   : read FSM states (idle, memory read cycle, data valid).
package jtpopeye_obj_pkg;

  localparam int unsigned DefNb = 4;
  localparam int unsigned DefAw = 13;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StValid
  } obj_state_e;

endpackage

// File: rtl/jtpopeye_objbank_mem.sv
// One byte-wide object ROM bank: simple dual-port 2^AW x 8 RAM.
//   clk   : clock
//   we    : write strobe, waddr/wdata : write port
//   raddr : read address, rdata : registered read data (one cycle latency)
// Contents are intentionally not reset so a download survives a reset.
module jtpopeye_objbank_mem
  import jtpopeye_obj_pkg::*;
#(
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
    rdata <= ram[raddr];
  end

endmodule

// File: rtl/jtpopeye_objbank.sv
// Object ROM bank set: NB byte-wide banks filled by a download port and read
// together as one 8*NB-bit word through a small request/ok handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   prog_addr/bank/data : download byte address, target bank, byte
//   prog_we             : download strobe, one byte per high cycle
//   obj_cs, obj_addr    : read request (held until obj_ok) and address
//   obj_dout, obj_ok    : all bank bytes at obj_addr, and their valid flag
//   loaded              : per-bank download complete (2^AW bytes written)
//   chk_sum             : running sum of downloaded bytes, mod 2^16
// NB must be even and at least 2. Optional feature: define
// JTPOPEYE_OBJ_CHECKSUM_EN to build the checksum; otherwise chk_sum is 0.
module jtpopeye_objbank
  import jtpopeye_obj_pkg::*;
#(
  parameter int unsigned NB         = DefNb,
  parameter int unsigned AW         = DefAw,
  parameter bit          INV_ADDR   = 1'b1,
  parameter bit          SWAP_PAIRS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         prog_addr,
  input  logic [$clog2(NB)-1:0] prog_bank,
  input  logic [7:0]            prog_data,
  input  logic                  prog_we,
  input  logic                  obj_cs,
  input  logic [AW-1:0]         obj_addr,
  output logic [8*NB-1:0]       obj_dout,
  output logic                  obj_ok,
  output logic [NB-1:0]         loaded,
  output logic [15:0]           chk_sum
);

  localparam int unsigned BW = $clog2(NB);

  obj_state_e      state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      rd_byte [NB];
  logic [8*NB-1:0] rd_lanes;

  assign wr_addr = INV_ADDR ? ~prog_addr : prog_addr;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    // Lane b shows its pair partner when swapping is enabled.
    localparam int unsigned Src = SWAP_PAIRS ? (b ^ 1) : b;

    logic        bank_we;
    logic [AW:0] cnt_q;

    assign bank_we = prog_we && (prog_bank == BW'(b));

    jtpopeye_objbank_mem #(
      .AW(AW)
    ) u_mem (
      .clk  (clk),
      .we   (bank_we),
      .waddr(wr_addr),
      .wdata(prog_data),
      .raddr(obj_addr),
      .rdata(rd_byte[b])
    );

    assign rd_lanes[8*b +: 8] = rd_byte[Src];

    // Counter stops at 2^AW, so its MSB alone marks a full bank.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (bank_we && !cnt_q[AW]) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end
    end

    assign loaded[b] = cnt_q[AW];
  end

  // The RAM read port follows obj_addr directly, so rd_lanes holds the data
  // for the address sampled one edge earlier; addr_q remembers that address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      obj_ok   <= 1'b0;
      obj_dout <= '0;
    end else if (prog_we) begin
      // A download may be rewriting the banks: never report valid.
      state_q <= StIdle;
      obj_ok  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (obj_cs) begin
            state_q <= StRd;
            addr_q  <= obj_addr;
          end
        end
        StRd: begin
          if (!obj_cs) begin
            state_q <= StIdle;
          end else if (obj_addr != addr_q) begin
            addr_q <= obj_addr;
          end else begin
            state_q  <= StValid;
            obj_ok   <= 1'b1;
            obj_dout <= rd_lanes;
          end
        end
        StValid: begin
          if (!obj_cs) begin
            state_q <= StIdle;
            obj_ok  <= 1'b0;
          end else if (obj_addr != addr_q) begin
            state_q <= StRd;
            addr_q  <= obj_addr;
            obj_ok  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          obj_ok  <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTPOPEYE_OBJ_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (prog_we) begin
      sum_q <= sum_q + {8'd0, prog_data};
    end
  end

  assign chk_sum = sum_q;
`else
  assign chk_sum = '0;
`endif

endmodule
